// File: rtl/ita_package.sv
// Shared ITA types and constants.
//   counter_t : width of every tile/beat counter in the datapath
//   step_e    : datapath phase code consumed by ita_masking
//   M, N      : default tile edge and PE column count; BEATS = beats per tile
package ita_package;

  localparam int unsigned M            = 64;
  localparam int unsigned N            = 16;
  localparam int unsigned BEATS        = M * M / N;
  localparam int unsigned CounterWidth = 16;

  typedef logic [CounterWidth-1:0] counter_t;

  typedef enum logic [1:0] {
    Idle = 2'd0,
    QK   = 2'd1,
    AV   = 2'd2
  } step_e;

endpackage

// File: rtl/ita_loop_counter.sv
// One level of the sequencer's loop nest.
//   clk_i, rst_ni : clock, async active-low reset
//   en_i          : advance this level by one
//   clear_i       : synchronous clear to 0 (wins over en_i)
//   max_i         : last value before wrapping back to 0
//   cnt_o         : current count
//   wrap_o        : advancing from max_i this cycle; feeds en_i of the next outer level
module ita_loop_counter
  import ita_package::*;
(
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     en_i,
  input  logic     clear_i,
  input  counter_t max_i,
  output counter_t cnt_o,
  output logic     wrap_o
);

  assign wrap_o = en_i && (cnt_o == max_i);

  // Count register: clear, else wrap to 0 or increment on enable.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_o <= '0;
    end else if (clear_i) begin
      cnt_o <= '0;
    end else if (en_i) begin
      cnt_o <= wrap_o ? '0 : cnt_o + counter_t'(1);
    end
  end

endmodule

// File: rtl/ita_attn_tile_sequencer.sv
// Sequences the QK and AV phases of the ITA datapath, producing the beat
// counter, tile coordinates, inner-tile index and step code for ita_masking.
//   clk_i, rst_ni       : clock, async active-low reset
//   start_i             : start pulse, honoured only in IDLE
//   tile_s/p/e_i        : sequence, projection and embedding tile counts (latched at start)
//   ready_i             : datapath accepts a beat this cycle
//   step_o              : Idle / QK / AV
//   calc_en_o           : beat issued this cycle (combinational from state and ready_i)
//   count_o             : beat within tile
//   tile_x_o, tile_y_o  : output tile column / row
//   inner_o             : inner-loop tile index
//   last_inner_tile_o   : inner_o is the last inner index of the current phase
//   busy_o, done_o      : not idle / one-cycle completion pulse
module ita_attn_tile_sequencer
  import ita_package::*;
#(
  parameter int unsigned M = ita_package::M,
  parameter int unsigned N = ita_package::N
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     start_i,
  input  counter_t tile_s_i,
  input  counter_t tile_p_i,
  input  counter_t tile_e_i,
  input  logic     ready_i,
  output step_e    step_o,
  output logic     calc_en_o,
  output counter_t count_o,
  output counter_t tile_x_o,
  output counter_t tile_y_o,
  output counter_t inner_o,
  output logic     last_inner_tile_o,
  output logic     busy_o,
  output logic     done_o
);

  localparam int unsigned TileBeats = M * M / N;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StQk   = 2'd1,
    StAv   = 2'd2,
    StDone = 2'd3
  } seq_state_e;

  seq_state_e state_q, state_d;
  counter_t   cfg_s_q, cfg_p_q, cfg_e_q;
  counter_t   inner_max, x_max, y_max;
  logic       in_phase;
  logic       clear;
  logic       count_wrap, inner_wrap, x_wrap, y_wrap;
  logic       start_ok;

  assign start_ok = start_i && (state_q == StIdle);
  assign in_phase = (state_q == StQk) || (state_q == StAv);
  assign clear    = (state_q == StIdle);

  // Configuration latched once per run; later input changes are ignored.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cfg_s_q <= '0;
      cfg_p_q <= '0;
      cfg_e_q <= '0;
    end else if (start_ok) begin
      cfg_s_q <= tile_s_i;
      cfg_p_q <= tile_p_i;
      cfg_e_q <= tile_e_i;
    end
  end

  // Per-phase wrap limits: QK loops over embedding tiles, AV over sequence tiles.
  always_comb begin
    inner_max = cfg_e_q - counter_t'(1);
    x_max     = cfg_s_q - counter_t'(1);
    y_max     = cfg_s_q - counter_t'(1);
    if (state_q == StAv) begin
      inner_max = cfg_s_q - counter_t'(1);
      x_max     = cfg_p_q - counter_t'(1);
    end
  end

  // Loop nest, innermost first; the outermost wrap ends the phase and leaves
  // every level at 0, so AV starts on the cycle right after the last QK beat.
  ita_loop_counter u_count (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (calc_en_o),
    .clear_i(clear),
    .max_i  (counter_t'(TileBeats - 1)),
    .cnt_o  (count_o),
    .wrap_o (count_wrap)
  );

  ita_loop_counter u_inner (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (count_wrap),
    .clear_i(clear),
    .max_i  (inner_max),
    .cnt_o  (inner_o),
    .wrap_o (inner_wrap)
  );

  ita_loop_counter u_tile_x (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (inner_wrap),
    .clear_i(clear),
    .max_i  (x_max),
    .cnt_o  (tile_x_o),
    .wrap_o (x_wrap)
  );

  ita_loop_counter u_tile_y (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (x_wrap),
    .clear_i(clear),
    .max_i  (y_max),
    .cnt_o  (tile_y_o),
    .wrap_o (y_wrap)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a zero tile count skips straight to DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          if ((tile_s_i == '0) || (tile_p_i == '0) || (tile_e_i == '0)) begin
            state_d = StDone;
          end else begin
            state_d = StQk;
          end
        end
      end
      StQk:    if (y_wrap) state_d = StAv;
      StAv:    if (y_wrap) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output decode from the registered state.
  always_comb begin
    step_o            = Idle;
    calc_en_o         = 1'b0;
    busy_o            = 1'b0;
    done_o            = 1'b0;
    last_inner_tile_o = 1'b0;
    case (state_q)
      StQk: step_o = QK;
      StAv: step_o = AV;
      default: step_o = Idle;
    endcase
    if (in_phase) begin
      calc_en_o         = ready_i;
      last_inner_tile_o = (inner_o == inner_max);
    end
    busy_o = (state_q != StIdle);
    done_o = (state_q == StDone);
  end

endmodule

// File: tb/tb_ita_attn_tile_sequencer.sv
// Directed bench for ita_attn_tile_sequencer with M=8, N=4 (16 beats per tile).
module tb_ita_attn_tile_sequencer;
  import ita_package::*;

  localparam int unsigned TbM     = 8;
  localparam int unsigned TbN     = 4;
  localparam int unsigned TbBeats = 16;
  localparam int          CycLimit = 2000;

  typedef struct packed {
    logic [1:0] step;
    counter_t   cnt;
    counter_t   inner;
    counter_t   x;
    counter_t   y;
    logic       last;
  } beat_t;

  logic     clk_i = 1'b0;
  logic     rst_ni;
  logic     start_i;
  counter_t tile_s_i, tile_p_i, tile_e_i;
  logic     ready_i;
  step_e    step_o;
  logic     calc_en_o;
  counter_t count_o, tile_x_o, tile_y_o, inner_o;
  logic     last_inner_tile_o, busy_o, done_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  ita_attn_tile_sequencer #(.M(TbM), .N(TbN)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .start_i          (start_i),
    .tile_s_i         (tile_s_i),
    .tile_p_i         (tile_p_i),
    .tile_e_i         (tile_e_i),
    .ready_i          (ready_i),
    .step_o           (step_o),
    .calc_en_o        (calc_en_o),
    .count_o          (count_o),
    .tile_x_o         (tile_x_o),
    .tile_y_o         (tile_y_o),
    .inner_o          (inner_o),
    .last_inner_tile_o(last_inner_tile_o),
    .busy_o           (busy_o),
    .done_o           (done_o)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic beat_t dut_beat();
    beat_t b;
    b.step  = step_o;
    b.cnt   = count_o;
    b.inner = inner_o;
    b.x     = tile_x_o;
    b.y     = tile_y_o;
    b.last  = last_inner_tile_o;
    return b;
  endfunction

  // Runs one start..done sequence. Every cycle the visible counters must equal
  // the next beat to issue (so they are frozen while ready_i=0), calc_en must
  // follow ready_i while beats remain, and done must fire on the first cycle
  // with nothing left. exp_done_cyc counts clock edges from the start edge.
  task automatic run_seq(input int s, input int p, input int e, input bit toggle,
                         input int restart_cyc, input int exp_qk, input int exp_av,
                         input int exp_done_cyc);
    beat_t q[$];
    int    n_qk = 0;
    int    n_av = 0;
    int    cyc;
    bit    fin = 1'b0;
    if (s > 0 && p > 0 && e > 0) begin
      for (int y = 0; y < s; y++)
        for (int x = 0; x < s; x++)
          for (int i = 0; i < e; i++)
            for (int c = 0; c < TbBeats; c++)
              q.push_back('{step: QK, cnt: counter_t'(c), inner: counter_t'(i),
                            x: counter_t'(x), y: counter_t'(y), last: (i == e - 1)});
      for (int y = 0; y < s; y++)
        for (int x = 0; x < p; x++)
          for (int i = 0; i < s; i++)
            for (int c = 0; c < TbBeats; c++)
              q.push_back('{step: AV, cnt: counter_t'(c), inner: counter_t'(i),
                            x: counter_t'(x), y: counter_t'(y), last: (i == s - 1)});
    end
    @(posedge clk_i); #1;
    start_i  = 1'b1;
    tile_s_i = counter_t'(s);
    tile_p_i = counter_t'(p);
    tile_e_i = counter_t'(e);
    ready_i  = 1'b1;
    @(posedge clk_i); #1;
    start_i  = 1'b0;
    tile_s_i = counter_t'(3);
    tile_p_i = counter_t'(2);
    tile_e_i = counter_t'(5);
    cyc = 1;
    while (!fin) begin
      ready_i = toggle ? cyc[0] : 1'b1;
      start_i = (cyc == restart_cyc);
      @(negedge clk_i);
      check_eq("calc_en", calc_en_o, ready_i && (q.size() > 0));
      check_eq("busy", busy_o, 1'b1);
      check_eq("done", done_o, q.size() == 0);
      if (q.size() > 0) begin
        check_eq("beat", dut_beat(), q[0]);
        if (calc_en_o) begin
          if (q[0].step == AV) n_av++;
          else n_qk++;
          q.delete(0);
        end
      end else begin
        check_eq("done_cycle", cyc, exp_done_cyc);
        fin = 1'b1;
      end
      if (!fin && cyc >= CycLimit) begin
        check_eq("timeout", 1'b1, 1'b0);
        fin = 1'b1;
      end
      @(posedge clk_i); #1;
      cyc++;
    end
    start_i = 1'b0;
    ready_i = 1'b1;
    @(negedge clk_i);
    check_eq("idle_busy", busy_o, 1'b0);
    check_eq("idle_done", done_o, 1'b0);
    check_eq("idle_step", step_o, Idle);
    check_eq("idle_calc", calc_en_o, 1'b0);
    check_eq("qk_total", n_qk, exp_qk);
    check_eq("av_total", n_av, exp_av);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq(tag, {step_o, calc_en_o, count_o, tile_x_o, tile_y_o, inner_o,
                   last_inner_tile_o, busy_o, done_o}, '0);
  endtask

  initial begin
    rst_ni   = 1'b0;
    start_i  = 1'b0;
    tile_s_i = '0;
    tile_p_i = '0;
    tile_e_i = '0;
    ready_i  = 1'b1;
    #1;
    check_reset_outputs("reset_state");
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;

    // 1x1x1: 16 QK + 16 AV beats, done 33 edges after the start edge.
    run_seq(1, 1, 1, 1'b0, 0, 16, 16, 33);
    // s=2 e=3 p=1: QK 2*2*3*16, AV 2*1*2*16.
    run_seq(2, 1, 3, 1'b0, 0, 192, 64, 257);
    // Half-rate ready: beats on odd cycles only, last beat at 63.
    run_seq(1, 1, 1, 1'b1, 0, 16, 16, 64);
    // Zero embedding tiles: straight to DONE.
    run_seq(1, 1, 0, 1'b0, 0, 0, 0, 1);
    // Start re-pulsed mid-QK with a different config is ignored.
    run_seq(1, 1, 1, 1'b0, 10, 16, 16, 33);

    // Reset during AV at count 7: AV beat k lands on cycle 17+k.
    @(posedge clk_i); #1;
    start_i  = 1'b1;
    tile_s_i = counter_t'(1);
    tile_p_i = counter_t'(1);
    tile_e_i = counter_t'(1);
    ready_i  = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (23) @(posedge clk_i);
    @(negedge clk_i);
    check_eq("pre_rst_step", step_o, AV);
    check_eq("pre_rst_count", count_o, counter_t'(7));
    rst_ni = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    repeat (2) begin
      @(negedge clk_i);
      check_eq("rst_no_done", done_o, 1'b0);
    end
    rst_ni = 1'b1;
    run_seq(1, 1, 1, 1'b0, 0, 16, 16, 33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
